// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with a one-entry valid/ready output register.
// Define PARITY_CHECK_EN to add a trailing even-parity bit to each frame.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       SIn,
  input  logic                       SIn_Valid,
  input  logic                       Start,
  output logic [WIDTH-1:0]           Data_Out,
  output logic                       Out_Valid,
  input  logic                       Out_Ready,
  output logic                       Busy,
  output logic [$clog2(WIDTH+1)-1:0] Bit_Count,
  output logic                       Frame_Err,
  output logic                       Overrun,
  output logic                       Parity_Err
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] loaded;
  logic [WIDTH-1:0] word;
  logic             take_word;
`ifdef PARITY_CHECK_EN
  logic             word_par_err;
`endif

  // In parity mode the final bit is the parity bit, so the word is already complete in shift_reg.
  always_comb begin
    shifted   = MSB_FIRST ? {shift_reg[WIDTH-2:0], SIn} : {SIn, shift_reg[WIDTH-1:1]};
    loaded    = MSB_FIRST ? {{(WIDTH-1){1'b0}}, SIn} : {SIn, {(WIDTH-1){1'b0}}};
    take_word = !Out_Valid || Out_Ready;
`ifdef PARITY_CHECK_EN
    word         = shift_reg;
    word_par_err = (^shift_reg) ^ SIn;
`else
    word         = shifted;
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      Data_Out  <= '0;
      Bit_Count <= '0;
      Out_Valid <= 1'b0;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
      Parity_Err <= 1'b0;
`endif
    end else begin
      Frame_Err <= 1'b0;
      if (Out_Valid && Out_Ready) begin
        Out_Valid <= 1'b0;
      end
      if (SIn_Valid) begin
        case (state)
          IDLE: begin
            if (Start) begin
              shift_reg <= loaded;
              Bit_Count <= CW'(1);
              state     <= SHIFT;
            end
          end
          SHIFT: begin
            if (Start) begin
              shift_reg <= loaded;
              Bit_Count <= CW'(1);
              Frame_Err <= 1'b1;
            end else if (Bit_Count == LAST_COUNT) begin
              state     <= IDLE;
              Bit_Count <= '0;
              // A pending word that is not being accepted wins; the new one is dropped.
              if (take_word) begin
                Data_Out  <= word;
                Out_Valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                Parity_Err <= word_par_err;
`endif
              end else begin
                Overrun <= 1'b1;
              end
            end else begin
              shift_reg <= shifted;
              Bit_Count <= Bit_Count + CW'(1);
            end
          end
        endcase
      end
    end
  end

  assign Busy = (state == SHIFT);

`ifndef PARITY_CHECK_EN
  assign Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=4, MSB_FIRST=1).
module tb_sipo_deserializer;

  logic       Clock;
  logic       Reset;
  logic       SIn;
  logic       SIn_Valid;
  logic       Start;
  logic [3:0] Data_Out;
  logic       Out_Valid;
  logic       Out_Ready;
  logic       Busy;
  logic [2:0] Bit_Count;
  logic       Frame_Err;
  logic       Overrun;
  logic       Parity_Err;

  int tests_run;
  int tests_failed;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SIn        (SIn),
    .SIn_Valid  (SIn_Valid),
    .Start      (Start),
    .Data_Out   (Data_Out),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Busy       (Busy),
    .Bit_Count  (Bit_Count),
    .Frame_Err  (Frame_Err),
    .Overrun    (Overrun),
    .Parity_Err (Parity_Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Called at a falling edge; applies inputs, lets one rising edge pass, returns at the next falling edge.
  task automatic clk_bit(input logic v, input logic s, input logic b);
    SIn_Valid = v;
    Start     = s;
    SIn       = b;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic close_frame(input logic [3:0] w);
`ifdef PARITY_CHECK_EN
    clk_bit(1'b1, 1'b0, ^w);
`endif
  endtask

  task automatic send_frame(input logic [3:0] w, input logic rdy_last);
    for (int i = 3; i >= 0; i--) begin
`ifndef PARITY_CHECK_EN
      if (i == 0) Out_Ready = rdy_last;
`endif
      clk_bit(1'b1, (i == 3), w[i]);
    end
`ifdef PARITY_CHECK_EN
    Out_Ready = rdy_last;
    clk_bit(1'b1, 1'b0, ^w);
`endif
  endtask

  task automatic test_reset();
    Reset = 1'b0; SIn = 1'b0; SIn_Valid = 1'b0; Start = 1'b0; Out_Ready = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    tests_run++;
    if ({Data_Out, Out_Valid, Busy, Bit_Count, Frame_Err, Overrun, Parity_Err} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h expected 000",
               {Data_Out, Out_Valid, Busy, Bit_Count, Frame_Err, Overrun, Parity_Err});
    end
    Reset = 1'b1;
    clk_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_basic_frame();
    Out_Ready = 1'b1;
    clk_bit(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (Bit_Count !== 3'd1 || Busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_first_bit: got count=%0d busy=%b expected count=1 busy=1", Bit_Count, Busy);
    end
    clk_bit(1'b1, 1'b0, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (Bit_Count !== 3'd3 || Out_Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_third_bit: got count=%0d valid=%b expected count=3 valid=0", Bit_Count, Out_Valid);
    end
    clk_bit(1'b1, 1'b0, 1'b1);
    close_frame(4'b0101);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b0101 || Busy !== 1'b0 || Bit_Count !== 3'd0 || Overrun !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_complete: got valid=%b data=%b busy=%b count=%0d ovr=%b expected 1 0101 0 0 0",
               Out_Valid, Data_Out, Busy, Bit_Count, Overrun);
    end
    clk_bit(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_consumed: got valid=%b expected 0", Out_Valid);
    end
  endtask

  task automatic test_gapped_frame();
    logic [2:0] exp_cnt [7];
    logic       vv [7];
    logic       ss [7];
    logic       bb [7];
    vv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ss = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
    for (int i = 0; i < 6; i++) begin
      clk_bit(vv[i], ss[i], bb[i]);
      tests_run++;
      if (Bit_Count !== exp_cnt[i] || Frame_Err !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL gapped_count[%0d]: got count=%0d ferr=%b expected count=%0d ferr=0",
                 i, Bit_Count, Frame_Err, exp_cnt[i]);
      end
    end
    clk_bit(vv[6], ss[6], bb[6]);
    close_frame(4'b0101);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL gapped_word: got valid=%b data=%b expected 1 0101", Out_Valid, Data_Out);
    end
    clk_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_ignore();
    clk_bit(1'b1, 1'b0, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b1);
    tests_run++;
    if (Busy !== 1'b0 || Bit_Count !== 3'd0 || Out_Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ignore: got busy=%b count=%0d valid=%b expected 0 0 0", Busy, Bit_Count, Out_Valid);
    end
  endtask

  task automatic test_overrun();
    Out_Ready = 1'b0;
    send_frame(4'b0101, 1'b0);
    clk_bit(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b0101 || Overrun !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overrun_hold: got valid=%b data=%b ovr=%b expected 1 0101 0", Out_Valid, Data_Out, Overrun);
    end
    send_frame(4'b1100, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b0101 || Overrun !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overrun_drop: got valid=%b data=%b ovr=%b expected 1 0101 1", Out_Valid, Data_Out, Overrun);
    end
    Out_Ready = 1'b1;
    clk_bit(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b0 || Overrun !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overrun_release: got valid=%b ovr=%b expected 0 1", Out_Valid, Overrun);
    end
  endtask

  task automatic test_resync();
    Out_Ready = 1'b1;
    clk_bit(1'b1, 1'b1, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b1);
    clk_bit(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (Frame_Err !== 1'b1 || Bit_Count !== 3'd1 || Busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL resync_pulse: got ferr=%b count=%0d busy=%b expected 1 1 1", Frame_Err, Bit_Count, Busy);
    end
    clk_bit(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (Frame_Err !== 1'b0 || Bit_Count !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL resync_one_cycle: got ferr=%b count=%0d expected 0 2", Frame_Err, Bit_Count);
    end
    clk_bit(1'b1, 1'b0, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b1);
    close_frame(4'b0011);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b0011) begin
      tests_failed++;
      $display("[TB] FAIL resync_word: got valid=%b data=%b expected 1 0011", Out_Valid, Data_Out);
    end
    clk_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    clk_bit(1'b1, 1'b1, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b1);
    Reset = 1'b0;
    #1;
    tests_run++;
    if ({Data_Out, Out_Valid, Busy, Bit_Count, Frame_Err, Overrun, Parity_Err} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got %h expected 000",
               {Data_Out, Out_Valid, Busy, Bit_Count, Frame_Err, Overrun, Parity_Err});
    end
    SIn_Valid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    clk_bit(1'b0, 1'b0, 1'b0);
    send_frame(4'b1010, 1'b1);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b1010 || Overrun !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_word: got valid=%b data=%b ovr=%b expected 1 1010 0", Out_Valid, Data_Out, Overrun);
    end
    clk_bit(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    Out_Ready = 1'b0;
    send_frame(4'b1001, 1'b0);
    send_frame(4'b0110, 1'b1);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b0110 || Overrun !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: got valid=%b data=%b ovr=%b expected 1 0110 0", Out_Valid, Data_Out, Overrun);
    end
    clk_bit(1'b0, 1'b0, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back_drain: got valid=%b expected 0", Out_Valid);
    end
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    Out_Ready = 1'b1;
    clk_bit(1'b1, 1'b1, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b0);
    clk_bit(1'b1, 1'b0, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (Bit_Count !== 3'd4 || Out_Valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL parity_wait: got count=%0d valid=%b expected 4 0", Bit_Count, Out_Valid);
    end
    clk_bit(1'b1, 1'b0, 1'b1);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b1010 || Parity_Err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL parity_bad: got valid=%b data=%b perr=%b expected 1 1010 1", Out_Valid, Data_Out, Parity_Err);
    end
    clk_bit(1'b1, 1'b1, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b0);
    clk_bit(1'b1, 1'b0, 1'b1);
    clk_bit(1'b1, 1'b0, 1'b0);
    clk_bit(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (Out_Valid !== 1'b1 || Data_Out !== 4'b1010 || Parity_Err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL parity_good: got valid=%b data=%b perr=%b expected 1 1010 0", Out_Valid, Data_Out, Parity_Err);
    end
    clk_bit(1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_frame();
    test_gapped_frame();
    test_idle_ignore();
    test_overrun();
    test_resync();
    test_mid_reset();
    test_back_to_back();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
